// File: rtl/fb_writer_pkg.sv
// fb_writer_pkg: opcodes, command record, FSM states and frame-buffer size defaults for fb_rect_writer.
package fb_writer_pkg;
  localparam int FB_WIDTH_DEF = 320;
  localparam int FB_HEIGHT_DEF = 180;
  typedef enum logic [1:0] {OP_NOP = 2'd0, OP_FILL = 2'd1, OP_SWAP = 2'd2, OP_CHECKER = 2'd3} op_t;
  typedef enum logic [1:0] {IDLE, DRAW, SWAP} state_t;
  typedef struct packed {
    op_t op;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] w;
    logic [15:0] h;
    logic [15:0] color;
  } cmd_t;
endpackage

// File: rtl/fb_rect_writer_if.sv
// frame_buffer_bus: command handshake into the rectangle writer and its pixel-write/swap side.
interface frame_buffer_bus #(
  parameter int FB_WIDTH = fb_writer_pkg::FB_WIDTH_DEF,
  parameter int FB_HEIGHT = fb_writer_pkg::FB_HEIGHT_DEF
);
  logic cmd_valid_in;
  logic cmd_ready_out;
  logic [1:0] cmd_op_in;
  logic [$clog2(FB_WIDTH)-1:0] cmd_x_in;
  logic [$clog2(FB_HEIGHT)-1:0] cmd_y_in;
  logic [$clog2(FB_WIDTH):0] cmd_w_in;
  logic [$clog2(FB_HEIGHT):0] cmd_h_in;
  logic [15:0] cmd_color_in;
  logic [$clog2(FB_WIDTH*FB_HEIGHT)-1:0] write_addr_out;
  logic [15:0] write_data_out;
  logic write_enable_out;
  logic swap_buffer_out;
  logic busy_out;
  modport master(
    input cmd_valid_in, cmd_op_in, cmd_x_in, cmd_y_in, cmd_w_in, cmd_h_in, cmd_color_in,
    output cmd_ready_out, write_addr_out, write_data_out, write_enable_out, swap_buffer_out, busy_out
  );
  modport slave(
    output cmd_valid_in, cmd_op_in, cmd_x_in, cmd_y_in, cmd_w_in, cmd_h_in, cmd_color_in,
    input cmd_ready_out, write_addr_out, write_data_out, write_enable_out, swap_buffer_out, busy_out
  );
endinterface

// File: rtl/fb_rect_clip.sv
// fb_rect_clip: clips a rectangle to the frame buffer, giving exclusive end column/row and an empty flag.
module fb_rect_clip #(
  parameter int FB_WIDTH = fb_writer_pkg::FB_WIDTH_DEF,
  parameter int FB_HEIGHT = fb_writer_pkg::FB_HEIGHT_DEF
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] w,
  input  logic [15:0] h,
  output logic [15:0] x_end,
  output logic [15:0] y_end,
  output logic        empty
);
  logic [16:0] xs, ys;
  always_comb begin
    xs = 17'(x) + 17'(w);
    ys = 17'(y) + 17'(h);
    x_end = xs > 17'(FB_WIDTH) ? 16'(FB_WIDTH) : xs[15:0];
    y_end = ys > 17'(FB_HEIGHT) ? 16'(FB_HEIGHT) : ys[15:0];
    empty = w == 16'd0 || h == 16'd0 || x >= 16'(FB_WIDTH) || y >= 16'(FB_HEIGHT);
  end
endmodule

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: streams clipped FILL/CHECKER rectangles as one pixel write per cycle, plus buffer swaps.
// Define FB_RECT_CHECKER_EN to draw CHECKER with alternating colour; otherwise CHECKER acts as NOP.
module fb_rect_writer
  import fb_writer_pkg::*;
#(
  parameter int FB_WIDTH = FB_WIDTH_DEF,
  parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
  input logic clk_in,
  input logic rst_n_in,
  frame_buffer_bus.master bus
);
  localparam int AW = $clog2(FB_WIDTH*FB_HEIGHT);
  state_t state, state_n;
  cmd_t cmd;
  logic [15:0] x_end, y_end, x_end_q, y_end_q, x0, cx, cy, cx_n, cy_n, color, c_n, data, data_n;
  logic [AW-1:0] row, row_n, addr, addr_n;
  logic empty, accept, draw_op, we, we_n, swap, swap_n;
`ifdef FB_RECT_CHECKER_EN
  logic chk;
  assign draw_op = cmd.op == OP_FILL || cmd.op == OP_CHECKER;
`else
  assign draw_op = cmd.op == OP_FILL;
`endif
  assign cmd = '{op: op_t'(bus.cmd_op_in), x: 16'(bus.cmd_x_in), y: 16'(bus.cmd_y_in),
                 w: 16'(bus.cmd_w_in), h: 16'(bus.cmd_h_in), color: bus.cmd_color_in};
  assign accept = state == IDLE && bus.cmd_valid_in;
  fb_rect_clip #(.FB_WIDTH(FB_WIDTH), .FB_HEIGHT(FB_HEIGHT)) u_clip (
    .x(cmd.x), .y(cmd.y), .w(cmd.w), .h(cmd.h), .x_end(x_end), .y_end(y_end), .empty(empty)
  );
  always_comb begin
    state_n = state;
    cx_n = cx;
    cy_n = cy;
    row_n = row;
    addr_n = addr;
    c_n = accept ? cmd.color : color;
    we_n = 1'b0;
    swap_n = 1'b0;
    if (accept) begin
      if (cmd.op == OP_SWAP) begin
        state_n = SWAP;
        swap_n = 1'b1;
      end else if (draw_op && !empty) begin
        state_n = DRAW;
        we_n = 1'b1;
        cx_n = cmd.x;
        cy_n = cmd.y;
        row_n = AW'(cmd.y * FB_WIDTH);
        addr_n = row_n + AW'(cmd.x);
      end
    end else if (state == SWAP) begin
      state_n = IDLE;
    end else if (state == DRAW) begin
      // row wrap is folded into the same cycle so the stream never stalls
      if (cx + 16'd1 < x_end_q) begin
        cx_n = cx + 16'd1;
        addr_n = addr + AW'(1);
        we_n = 1'b1;
      end else if (cy + 16'd1 < y_end_q) begin
        cx_n = x0;
        cy_n = cy + 16'd1;
        row_n = row + AW'(FB_WIDTH);
        addr_n = row_n + AW'(x0);
        we_n = 1'b1;
      end else begin
        state_n = IDLE;
      end
    end
`ifdef FB_RECT_CHECKER_EN
    data_n = we_n ? ((((accept ? cmd.op == OP_CHECKER : chk)) && (cx_n[0] ^ cy_n[0])) ? ~c_n : c_n) : data;
`else
    data_n = we_n ? c_n : data;
`endif
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= IDLE;
      {cx, cy, x0, x_end_q, y_end_q, color, data} <= '0;
      {row, addr} <= '0;
      {we, swap} <= '0;
`ifdef FB_RECT_CHECKER_EN
      chk <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cx <= cx_n;
      cy <= cy_n;
      row <= row_n;
      addr <= addr_n;
      data <= data_n;
      we <= we_n;
      swap <= swap_n;
      if (accept) begin
        x0 <= cmd.x;
        x_end_q <= x_end;
        y_end_q <= y_end;
        color <= cmd.color;
`ifdef FB_RECT_CHECKER_EN
        chk <= cmd.op == OP_CHECKER;
`endif
      end
    end
  end
  assign bus.cmd_ready_out = state == IDLE;
  assign bus.busy_out = state != IDLE;
  assign bus.write_addr_out = addr;
  assign bus.write_data_out = data;
  assign bus.write_enable_out = we;
  assign bus.swap_buffer_out = swap;
endmodule

// File: tb/tb_fb_rect_writer.sv
// tb_fb_rect_writer: table vectors, random commands against a loop-based pixel model, and a mid-draw reset.
module tb_fb_rect_writer;
  import fb_writer_pkg::*;
  localparam int W = 320;
  localparam int H = 180;
`ifdef FB_RECT_CHECKER_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif
  typedef struct {int addr; logic [15:0] data;} wr_t;
  typedef struct {logic [1:0] op; int x, y, w, h; logic [15:0] color; int n, fa, la; logic [15:0] fd; bit sw;} vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wr_t exp_q[$];
  int tests = 0, fails = 0, ea = 0;
  logic [15:0] ed = '0;
  always #5 clk = ~clk;
  frame_buffer_bus #(.FB_WIDTH(W), .FB_HEIGHT(H)) bus ();
  fb_rect_writer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic scramble();
    bus.cmd_op_in = 2'($urandom);
    bus.cmd_x_in = 9'($urandom);
    bus.cmd_y_in = 8'($urandom);
    bus.cmd_w_in = 10'($urandom);
    bus.cmd_h_in = 9'($urandom);
    bus.cmd_color_in = 16'($urandom);
  endtask

  // every visible pixel of the rectangle, row by row, straight from the drawing rules
  task automatic build_model(input logic [1:0] op, input int x, y, w, h, input logic [15:0] c);
    exp_q.delete();
    if (op == 2'd1 || (op == 2'd3 && CHK_EN))
      for (int yy = y; yy < y + h && yy < H; yy++)
        for (int xx = x; xx < x + w && xx < W; xx++)
          exp_q.push_back('{yy * W + xx, (op == 2'd3 && ((xx ^ yy) & 1) == 1) ? ~c : c});
  endtask

  task automatic run_cmd(input logic [1:0] op, input int x, y, w, h, input logic [15:0] c,
                         output int n, output int fa, output int la, output logic [15:0] fd, output bit sw);
    int rdy_t;
    build_model(op, x, y, w, h, c);
    rdy_t = (op == 2'd2) ? 2 : exp_q.size() + 1;
    n = 0; fa = -1; la = -1; fd = '0; sw = 1'b0;
    @(negedge clk);
    check("ready_before_cmd", bus.cmd_ready_out, 1);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_op_in = op;
    bus.cmd_x_in = 9'(x);
    bus.cmd_y_in = 8'(y);
    bus.cmd_w_in = 10'(w);
    bus.cmd_h_in = 9'(h);
    bus.cmd_color_in = c;
    @(negedge clk);
    bus.cmd_valid_in = 1'b0;
    scramble();
    for (int t = 1; t <= rdy_t; t++) begin
      if (t > 1) @(negedge clk);
      if (bus.write_enable_out) begin
        if (n == 0) begin fa = int'(bus.write_addr_out); fd = bus.write_data_out; end
        la = int'(bus.write_addr_out);
        n++;
      end
      if (bus.swap_buffer_out) sw = 1'b1;
      check("write_enable", bus.write_enable_out, t <= exp_q.size());
      check("swap_pulse", bus.swap_buffer_out, op == 2'd2 && t == 1);
      check("ready", bus.cmd_ready_out, t == rdy_t);
      check("busy", bus.busy_out, t != rdy_t);
      if (t <= exp_q.size()) begin
        ea = exp_q[t-1].addr;
        ed = exp_q[t-1].data;
        check("write_addr", 32'(bus.write_addr_out), ea);
        check("write_data", bus.write_data_out, ed);
      end else begin
        check("hold_addr", 32'(bus.write_addr_out), ea);
        check("hold_data", bus.write_data_out, ed);
      end
    end
  endtask

  initial begin
    vec_t v[11];
    int n, fa, la;
    logic [15:0] fd;
    bit sw;
    v[0]  = '{2'd1, 10, 5, 3, 2, 16'hF800, 6, 1610, 1932, 16'hF800, 1'b0};
    v[1]  = '{2'd1, 318, 179, 10, 10, 16'h1234, 2, 57598, 57599, 16'h1234, 1'b0};
    v[2]  = '{2'd1, 5, 5, 0, 4, 16'h5555, 0, 0, 0, 16'h0000, 1'b0};
    v[3]  = '{2'd1, 400, 0, 5, 5, 16'h5555, 0, 0, 0, 16'h0000, 1'b0};
    v[4]  = '{2'd2, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 1'b1};
    v[5]  = '{2'd0, 3, 3, 3, 3, 16'hFFFF, 0, 0, 0, 16'h0000, 1'b0};
    v[6]  = '{2'd3, 0, 0, 2, 2, 16'h0000, CHK_EN ? 4 : 0, 0, 321, 16'h0000, 1'b0};
    v[7]  = '{2'd1, 0, 0, 320, 1, 16'hABCD, 320, 0, 319, 16'hABCD, 1'b0};
    v[8]  = '{2'd1, 0, 178, 1, 5, 16'h07E0, 2, 56960, 57280, 16'h07E0, 1'b0};
    v[9]  = '{2'd1, 7, 180, 4, 4, 16'h1111, 0, 0, 0, 16'h0000, 1'b0};
    v[10] = '{2'd3, 1, 0, 2, 1, 16'h00FF, CHK_EN ? 2 : 0, 1, 2, 16'hFF00, 1'b0};
    bus.cmd_valid_in = 1'b0;
    scramble();
    #12;
    check("rst_we", bus.write_enable_out, 0);
    check("rst_swap", bus.swap_buffer_out, 0);
    check("rst_busy", bus.busy_out, 0);
    check("rst_addr", 32'(bus.write_addr_out), 0);
    check("rst_data", bus.write_data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", bus.cmd_ready_out, 1);
    foreach (v[i]) begin
      run_cmd(v[i].op, v[i].x, v[i].y, v[i].w, v[i].h, v[i].color, n, fa, la, fd, sw);
      check($sformatf("vec%0d_count", i), n, v[i].n);
      check($sformatf("vec%0d_swap", i), sw, v[i].sw);
      if (n > 0) begin
        check($sformatf("vec%0d_first_addr", i), fa, v[i].fa);
        check($sformatf("vec%0d_last_addr", i), la, v[i].la);
        check($sformatf("vec%0d_first_data", i), fd, v[i].fd);
      end
    end
    for (int i = 0; i < 40; i++)
      run_cmd(2'($urandom), int'($urandom_range(0, 330)), int'($urandom_range(0, 190)),
              int'($urandom_range(0, 24)), int'($urandom_range(0, 5)), 16'($urandom), n, fa, la, fd, sw);
    // reset pulse in the middle of a 100-pixel row
    @(negedge clk);
    bus.cmd_valid_in = 1'b1;
    bus.cmd_op_in = 2'd1;
    bus.cmd_x_in = 9'd0;
    bus.cmd_y_in = 8'd10;
    bus.cmd_w_in = 10'd100;
    bus.cmd_h_in = 9'd1;
    bus.cmd_color_in = 16'h07E0;
    @(negedge clk);
    bus.cmd_valid_in = 1'b0;
    for (int t = 0; t < 10; t++) begin
      if (t > 0) @(negedge clk);
      check("pre_reset_we", bus.write_enable_out, 1);
      check("pre_reset_addr", 32'(bus.write_addr_out), 3200 + t);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_we", bus.write_enable_out, 0);
    check("abort_busy", bus.busy_out, 0);
    check("abort_addr", 32'(bus.write_addr_out), 0);
    check("abort_data", bus.write_data_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ea = 0;
    ed = '0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check("post_reset_we", bus.write_enable_out, 0);
      check("post_reset_ready", bus.cmd_ready_out, 1);
    end
    run_cmd(2'd1, 10, 5, 3, 2, 16'hF800, n, fa, la, fd, sw);
    check("post_reset_fill_count", n, 6);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_rect_writer.md
FB_RECT_WRITER -- requirements
Module: fb_rect_writer

Interface
REQ-001 The block SHALL have parameter FB_WIDTH, default 320, meaning frame buffer width in pixels.
REQ-002 The block SHALL have parameter FB_HEIGHT, default 180, meaning frame buffer height in pixels.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Port clk_in  input  1  sole clock; all outputs are registered on its rising edge.
REQ-005 Port rst_n_in  input  1  asynchronous active-low reset.
REQ-006 Port cmd_valid_in  input  1  command present.
REQ-007 Port cmd_ready_out  output  1  block accepts the command this cycle.
REQ-008 Port cmd_op_in  input  2  opcode: NOP=0, FILL=1, SWAP=2, CHECKER=3.
REQ-009 Port cmd_x_in  input  $clog2(FB_WIDTH)  rectangle left column.
REQ-010 Port cmd_y_in  input  $clog2(FB_HEIGHT)  rectangle top row.
REQ-011 Port cmd_w_in  input  $clog2(FB_WIDTH)+1  rectangle width in pixels.
REQ-012 Port cmd_h_in  input  $clog2(FB_HEIGHT)+1  rectangle height in pixels.
REQ-013 Port cmd_color_in  input  16  RGB565 colour.
REQ-014 Port write_addr_out  output  $clog2(FB_WIDTH*FB_HEIGHT)  linear address, y*FB_WIDTH+x.
REQ-015 Port write_data_out  output  16  RGB565 pixel.
REQ-016 Port write_enable_out  output  1  single-cycle write strobe per pixel.
REQ-017 Port swap_buffer_out  output  1  single-cycle buffer swap pulse.
REQ-018 Port busy_out  output  1  high whenever the state is not IDLE.

Function
REQ-019 The FSM SHALL have the states IDLE, DRAW and SWAP.
REQ-020 cmd_ready_out SHALL equal (state==IDLE); a command transfers when cmd_valid_in && cmd_ready_out.
REQ-021 An accepted FILL or CHECKER command SHALL clip to x_end=min(x+w,FB_WIDTH) and y_end=min(y+h,FB_HEIGHT).
REQ-022 If the clipped area is empty (w==0, h==0, x>=FB_WIDTH or y>=FB_HEIGHT), the block SHALL stay in IDLE and produce no writes.
REQ-023 Otherwise the FSM SHALL enter DRAW, and the first write_enable_out SHALL occur in the cycle after acceptance.
REQ-024 DRAW SHALL emit exactly one pixel per cycle, row-major; no gap cycles are permitted, including at row ends.
REQ-025 Addresses SHALL be produced incrementally (row base += FB_WIDTH); no per-pixel multiplier is permitted.
REQ-026 After the last pixel at (x_end-1, y_end-1), the FSM SHALL return to IDLE, with cmd_ready_out high the following cycle.
REQ-027 An accepted SWAP SHALL enter the SWAP state for one cycle and assert swap_buffer_out for exactly one cycle, one cycle after acceptance; the FSM then returns to IDLE.
REQ-028 NOP SHALL be accepted and SHALL have no effect.
REQ-029 write_addr_out and write_data_out SHALL hold their last values when write_enable_out is low.
REQ-030 Command fields SHALL be latched at acceptance; input changes during DRAW SHALL be ignored.

Reset
REQ-031 While rst_n_in is low, state SHALL be IDLE and write_enable_out, swap_buffer_out, busy_out, write_addr_out and write_data_out SHALL be 0.
REQ-032 Reset asserted mid-DRAW SHALL abort the rectangle immediately, with no further write strobes.
REQ-033 After reset release, cmd_ready_out SHALL be 1.

Configuration
REQ-034 With FB_RECT_CHECKER_EN defined, CHECKER SHALL draw like FILL with pixel = ((x^y)&1) ? ~color : color.
REQ-035 Without FB_RECT_CHECKER_EN, CHECKER SHALL be accepted and treated as NOP, and the parity logic SHALL be absent.

Structure
REQ-036 Package fb_writer_pkg SHALL hold the opcode enum, the command struct, and the FB_WIDTH/FB_HEIGHT defaults.
REQ-037 The clip computation SHALL be in sub-module fb_rect_clip (combinational: command in, x_end/y_end/empty out).
REQ-038 The outputs SHALL connect directly to the WRITE side of frame_buffer_bus.

Verification
REQ-039 FILL x=10,y=5,w=3,h=2,color=16'hF800 -> 6 writes on 6 consecutive cycles, at addrs 1610,1611,1612,1930,1931,1932, all data F800.
REQ-040 FILL x=318,y=179,w=10,h=10 -> exactly 2 writes, at addrs 57598 and 57599; then ready.
REQ-041 FILL w=0, and FILL x=400 -> no writes; cmd_ready_out stays high.
REQ-042 SWAP -> swap_buffer_out high for exactly 1 cycle, 1 cycle after acceptance; no writes.
REQ-043 CHECKER x=0,y=0,w=2,h=2,color=16'h0000 -> with the macro, data 0000,FFFF,FFFF,0000; without the macro, no writes.
REQ-044 rst_n_in pulsed low during a 100-pixel FILL -> write_enable_out low the same cycle; idle and ready after release.
